// File: rtl/gnrc_pkg.sv
// Shared constants and helpers for the generic FIFO adapter blocks.
package gnrc_pkg;

    // Deepest upstream read latency the std->FWFT adapter is built for.
    localparam int RD_LAT_MAX = 3;

    // Local buffer depth needed to cover every read that can be in flight
    // plus the word being presented.
    function automatic int std2fwft_bd(input int rd_lat);
        return rd_lat + 1;
    endfunction

endpackage

// File: rtl/gnrc_fwft_fifo.sv
// Small first-word-fall-through FIFO: the head word is visible on rdata_o
// whenever valid_o is high. BYPASS=1 lets a write into an empty FIFO appear
// on the output in the same cycle.
module gnrc_fwft_fifo #(
    parameter int DW     = 32,
    parameter int DP     = 2,
    parameter bit BYPASS = 1'b0,
    localparam int AW    = (DP > 1) ? $clog2(DP) : 1,
    localparam int CW    = $clog2(DP + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          wen_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          ren_i,
    output logic [DW-1:0] rdata_o,
    output logic          valid_o
);

    logic [DW-1:0] mem_q [DP];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty_w, full_w, thru_w, push_w, pop_w;

    // Pointers wrap at DP, which need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DP - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Push/pop decode, next-state pointers and occupancy.
    always_comb begin
        empty_w = (cnt_q == '0);
        full_w  = (cnt_q == CW'(DP));
        thru_w  = BYPASS && empty_w && wen_i && ren_i;
        push_w  = wen_i && (!full_w || ren_i) && !thru_w;
        pop_w   = ren_i && !empty_w;
        wptr_d  = push_w ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop_w ? ptr_inc(rptr_q) : rptr_q;
        cnt_d   = cnt_q + CW'(push_w) - CW'(pop_w);
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    // Head word presentation; bypass forwards the incoming word when empty.
    always_comb begin
        valid_o = !empty_w || (BYPASS && wen_i);
        rdata_o = (BYPASS && empty_w) ? wdata_i : mem_q[rptr_q];
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage; cleared on reset so the output reads zero until first write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DP; i++) mem_q[i] <= '0;
        end else if (push_w && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/gnrc_std2fwft.sv
// Read-side adapter: drains a standard FIFO with fixed read latency RD_LAT
// and presents a first-word-fall-through valid/ready stream. Reads are
// prefetched under a credit count (buffered + in flight) so the local
// buffer can never overflow while sustaining one word per cycle.
// Optional feature macro: GNRC_STD2FWFT_LEVEL_EN adds level_o and an
// overflow assertion.
module gnrc_std2fwft
    import gnrc_pkg::*;
#(
    parameter int DW     = 32,
    parameter int RD_LAT = 1,
    localparam int BD    = std2fwft_bd(RD_LAT),
    localparam int CW    = $clog2(BD + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          empty_i,
    output logic          ren_o,
    input  logic [DW-1:0] rdata_i,
    output logic          valid_o,
    input  logic          ready_i,
`ifdef GNRC_STD2FWFT_LEVEL_EN
    output logic [CW-1:0] level_o,
`endif
    output logic [DW-1:0] data_o
);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("gnrc_std2fwft: RD_LAT out of range");
    end

    logic [RD_LAT-1:0] inflight_q, inflight_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pop_w, cap_w, ren_w;

    assign pop_w = valid_o & ready_i;
    // Last stage of the in-flight pipe marks the cycle rdata_i is valid.
    assign cap_w = inflight_q[RD_LAT-1];
    assign ren_o = ren_w;

    // Read strobe: issue only if the credit left after this cycle's pop
    // still fits the buffer. Held low during reset and flush.
    always_comb begin
        ren_w = !rst_i && !empty_i && !flush_i &&
                (({1'b0, cnt_q} - {{CW{1'b0}}, pop_w}) < (CW + 1)'(BD));
    end

    // In-flight shift register and credit count next state.
    always_comb begin
        inflight_d = '0;
        cnt_d      = '0;
        if (!flush_i) begin
            inflight_d[0] = ren_w;
            for (int i = 1; i < RD_LAT; i++) inflight_d[i] = inflight_q[i-1];
            cnt_d = cnt_q + CW'(ren_w) - CW'(pop_w);
        end
    end

    // Credit and in-flight state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

    gnrc_fwft_fifo #(
        .DW     (DW),
        .DP     (BD),
        .BYPASS (1'b0)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .flush_i (flush_i),
        .wen_i   (cap_w),
        .wdata_i (rdata_i),
        .ren_i   (pop_w),
        .rdata_o (data_o),
        .valid_o (valid_o)
    );

`ifdef GNRC_STD2FWFT_LEVEL_EN
    logic [CW-1:0] occ_w;

    assign level_o = cnt_q;
    assign occ_w   = cnt_q - CW'($countones(inflight_q));

    // A returning word must always find room in the buffer.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && cap_w && !pop_w)
            assert (occ_w != CW'(BD)) else $error("gnrc_std2fwft: capture into full buffer");
    end
`endif

endmodule

// File: tb/tb_gnrc_std2fwft.sv
// Bench for gnrc_std2fwft: three instances (RD_LAT=1,2,3) each fed by a
// behavioural standard FIFO returning sequential words. A scoreboard per
// instance queues every issued read and compares it against popped output.
module tb_gnrc_std2fwft;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        flush [N];
    logic        empty [N];
    logic        ren   [N];
    logic        valid [N];
    logic        ready [N];
    logic [31:0] rdata [N];
    logic [31:0] data  [N];
`ifdef GNRC_STD2FWFT_LEVEL_EN
    logic [2:0]  level [N];
`endif

    // Upstream model state.
    int unsigned issued [N];
    int unsigned avail  [N];
    logic [31:0] base   [N];
    bit          fe     [N];
    logic [31:0] pipe   [N][N];
    logic [31:0] exp_q  [N][$];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
`ifdef GNRC_STD2FWFT_LEVEL_EN
        logic [$clog2(g + 3)-1:0] lvl;
        assign level[g] = 3'(lvl);
`endif
        gnrc_std2fwft #(.DW(32), .RD_LAT(g + 1)) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .flush_i (flush[g]),
            .empty_i (empty[g]),
            .ren_o   (ren[g]),
            .rdata_i (rdata[g]),
            .valid_o (valid[g]),
            .ready_i (ready[g]),
`ifdef GNRC_STD2FWFT_LEVEL_EN
            .level_o (lvl),
`endif
            .data_o  (data[g])
        );
    end

    always_comb begin
        for (int g = 0; g < N; g++) begin
            empty[g] = fe[g] || (issued[g] >= avail[g]);
            rdata[g] = pipe[g][g];
        end
    end

    // Standard FIFO: word issued on ren returns RD_LAT cycles later.
    initial for (int g = 0; g < N; g++) issued[g] = 0;
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (ren[g]) issued[g] <= issued[g] + 1;
            pipe[g][0] <= ren[g] ? base[g] + 32'(issued[g]) : 32'hBAD0_0000;
            for (int j = 1; j < N; j++) pipe[g][j] <= pipe[g][j-1];
        end
    end

    // Scoreboard: pop/compare on accept, then record this cycle's read.
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                exp_q[g].delete();
            end else begin
                if (valid[g] && ready[g]) begin
                    checks++;
                    if (exp_q[g].size() == 0) begin
                        errors++;
                        $display("FAIL sb%0d unexpected word got %h want none", g, data[g]);
                    end else begin
                        logic [31:0] e;
                        e = exp_q[g].pop_front();
                        if (data[g] !== e) begin
                            errors++;
                            $display("FAIL sb%0d data got %h want %h", g, data[g], e);
                        end
                    end
                end
                if (flush[g]) exp_q[g].delete();
                else if (ren[g]) exp_q[g].push_back(base[g] + 32'(issued[g]));
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int g, input logic [31:0] first, input int unsigned n);
        base[g]  = first - 32'(issued[g]);
        avail[g] = issued[g] + n;
    endtask

    task automatic drain(input int g, input string nm);
        fe[g]    = 1'b0;
        avail[g] = issued[g];
        ready[g] = 1'b1;
        repeat (8) nxt();
        @(negedge clk);
        chk({nm, "_drain_valid"}, 32'(valid[g]), 32'd0);
        chk({nm, "_drain_sb"}, exp_q[g].size(), 32'd0);
        nxt();
        ready[g] = 1'b0;
    endtask

    typedef struct {
        bit          rdy;
        bit          eren;
        bit          evld;
        logic [31:0] edata;
    } bp_t;

    bp_t bp [9];

    initial begin
        bp[0] = '{1'b0, 1'b1, 1'b0, 32'h0};
        bp[1] = '{1'b0, 1'b1, 1'b0, 32'h0};
        bp[2] = '{1'b0, 1'b0, 1'b1, 32'h10};
        bp[3] = '{1'b0, 1'b0, 1'b1, 32'h10};
        bp[4] = '{1'b0, 1'b0, 1'b1, 32'h10};
        bp[5] = '{1'b1, 1'b1, 1'b1, 32'h10};
        bp[6] = '{1'b1, 1'b1, 1'b1, 32'h11};
        bp[7] = '{1'b0, 1'b0, 1'b1, 32'h12};
        bp[8] = '{1'b0, 1'b0, 1'b1, 32'h12};

        for (int g = 0; g < N; g++) begin
            flush[g] = 1'b0; ready[g] = 1'b0; fe[g] = 1'b0;
            base[g] = '0; avail[g] = 0;
        end

        // Reset state.
        #1;
        for (int g = 0; g < N; g++) begin
            chk($sformatf("rst_valid%0d", g), 32'(valid[g]), 32'd0);
            chk($sformatf("rst_ren%0d", g), 32'(ren[g]), 32'd0);
            chk($sformatf("rst_data%0d", g), data[g], 32'd0);
        end
        repeat (2) nxt();
        rst = 1'b0;

        // Streaming, RD_LAT=2: first word 3 cycles after empty falls, no bubbles.
        load(1, 32'h10, 16);
        ready[1] = 1'b1;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            chk($sformatf("str_ren c%0d", c), 32'(ren[1]), 32'(c <= 15));
            chk($sformatf("str_valid c%0d", c), 32'(valid[1]), 32'(c >= 3 && c <= 18));
            if (c >= 3 && c <= 18)
                chk($sformatf("str_data c%0d", c), data[1], 32'h10 + 32'(c - 3));
            nxt();
        end
        drain(1, "str");

        // Backpressure, RD_LAT=1: table of per-cycle stimulus and expectations.
        load(0, 32'h10, 16);
        for (int c = 0; c < 9; c++) begin
            ready[0] = bp[c].rdy;
            @(negedge clk);
            chk($sformatf("bp_ren c%0d", c), 32'(ren[0]), 32'(bp[c].eren));
            chk($sformatf("bp_valid c%0d", c), 32'(valid[0]), 32'(bp[c].evld));
            if (bp[c].evld) chk($sformatf("bp_data c%0d", c), data[0], bp[c].edata);
            nxt();
        end
        drain(0, "bp");

        // Empty toggling, RD_LAT=1: reads only where empty is low.
        load(0, 32'h40, 64);
        ready[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            fe[0] = (c % 2 == 0);
            @(negedge clk);
            chk($sformatf("tog_ren c%0d", c), 32'(ren[0]), 32'(c % 2 != 0));
            nxt();
        end
        drain(0, "tog");

        // Flush with one buffered word and one in flight, RD_LAT=1.
        load(0, 32'h60, 16);
        repeat (2) nxt();
        flush[0] = 1'b1;
        @(negedge clk);
        chk("fl_ren", 32'(ren[0]), 32'd0);
        chk("fl_valid_pre", 32'(valid[0]), 32'd1);
        chk("fl_data_pre", data[0], 32'h60);
        nxt();
        flush[0] = 1'b0;
        @(negedge clk);
        chk("fl_valid_c3", 32'(valid[0]), 32'd0);
        chk("fl_ren_c3", 32'(ren[0]), 32'd1);
        nxt();
        @(negedge clk);
        chk("fl_valid_c4", 32'(valid[0]), 32'd0);
        nxt();
        @(negedge clk);
        chk("fl_valid_c5", 32'(valid[0]), 32'd1);
        chk("fl_data_c5", data[0], 32'h62);
        nxt();
        drain(0, "fl");

        // RD_LAT=3 credit ramp under backpressure.
        load(2, 32'hA0, 16);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("lat3_ren c%0d", c), 32'(ren[2]), 32'(c <= 3));
            chk($sformatf("lat3_valid c%0d", c), 32'(valid[2]), 32'(c >= 4));
            if (c >= 4) chk($sformatf("lat3_data c%0d", c), data[2], 32'hA0);
`ifdef GNRC_STD2FWFT_LEVEL_EN
            chk($sformatf("lat3_level c%0d", c), 32'(level[2]), (c < 4) ? 32'(c) : 32'd4);
`endif
            nxt();
        end
        drain(2, "lat3");

        // Asynchronous reset mid-burst with two reads in flight, RD_LAT=2.
        load(1, 32'h80, 16);
        ready[1] = 1'b1;
        repeat (3) nxt();
        @(negedge clk);
        chk("ar_ren_pre", 32'(ren[1]), 32'd1);
        #1;
        rst = 1'b1;
        avail[1] = issued[1];
        #1;
        chk("ar_valid", 32'(valid[1]), 32'd0);
        chk("ar_ren", 32'(ren[1]), 32'd0);
        chk("ar_data", data[1], 32'd0);
        @(posedge clk);
        @(negedge clk);
        nxt();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("ar_stale c%0d", c), 32'(valid[1]), 32'd0);
            nxt();
        end
        load(1, 32'h90, 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("ar_post_valid c%0d", c), 32'(valid[1]), 32'(c == 3 || c == 4));
            if (c == 3) chk("ar_post_data", data[1], 32'h90);
            nxt();
        end
        drain(1, "ar");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
